// File: rtl/nibble_unpacker.sv
// nibble_unpacker: drops filler nibbles and packs live nibbles LSB-first into a word on a valid/ready port.
// Defining NIBBLE_UNPACKER_FILLER_CHECK_EN makes filler_err flag any filler nibble that is not 4'b0101.
module nibble_unpacker #(
  parameter int NIBBLES = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           din,
  input  logic [5:0]           sel,
  input  logic                 din_en,
  output logic [4*NIBBLES-1:0] word,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [CNT_W-1:0]     filler_cnt,
  output logic                 ovf,
  input  logic                 clr,
  output logic                 filler_err
);
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, ASSEMBLE, HOLD} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [4*NIBBLES-1:0] word_nx;
  logic live, fill, last, ovf_set;
  assign live = din_en & (sel == 6'b111111);
  assign fill = din_en & (sel != 6'b111111);
  assign last = idx == IW'(NIBBLES - 1);
  assign word_valid = state == HOLD;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    word_nx = word;
    ovf_set = 1'b0;
    case (state)
      IDLE: if (live) begin
        word_nx[3:0] = din;
        idx_nx = IW'(1);
        state_nx = ASSEMBLE;
      end
      ASSEMBLE: if (live) begin
        word_nx[4*idx +: 4] = din;
        idx_nx = last ? '0 : idx + 1'b1;
        state_nx = last ? HOLD : ASSEMBLE;
      end
      HOLD: if (word_ready) begin
        state_nx = live ? ASSEMBLE : IDLE;
        if (live) begin
          word_nx[3:0] = din;
          idx_nx = IW'(1);
        end
      end else ovf_set = live;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      word <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      word <= word_nx;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      filler_cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      filler_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (fill && !(&filler_cnt)) filler_cnt <= filler_cnt + 1'b1;
      if (ovf_set) ovf <= 1'b1;
    end
`ifdef NIBBLE_UNPACKER_FILLER_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) filler_err <= 1'b0;
    else if (clr) filler_err <= 1'b0;
    else if (fill && din != 4'b0101) filler_err <= 1'b1;
`else
  assign filler_err = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_unpacker.sv
// tb_nibble_unpacker: randomized and directed stimulus scored against a queue-based model of the unpacker.
module tb_nibble_unpacker;
  localparam int N = 4;
  localparam int CW = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] din = '0;
  logic [5:0] sel = '0;
  logic din_en = 1'b0, word_ready = 1'b0, clr = 1'b0;
  logic [4*N-1:0] word;
  logic word_valid, ovf, filler_err;
  logic [CW-1:0] filler_cnt;
  int tests = 0, fails = 0;
  logic [3:0] nibs[$];
  logic [4*N-1:0] expq[$];
  bit held = 0, m_ovf = 0, m_err = 0;
  int m_cnt = 0;
  bit e_valid = 0, e_ovf = 0, e_err = 0;
  int e_cnt = 0;

  nibble_unpacker #(.NIBBLES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .din_en(din_en),
    .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .filler_cnt(filler_cnt), .ovf(ovf), .clr(clr), .filler_err(filler_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    nibs.delete();
    expq.delete();
    held = 0; m_ovf = 0; m_err = 0; m_cnt = 0;
    e_valid = 0; e_ovf = 0; e_err = 0; e_cnt = 0;
  endtask

  task automatic cycle(input bit en, input logic [5:0] s, input logic [3:0] d, input bit rdy, input bit c);
    logic [4*N-1:0] w;
    bit lv;
    @(posedge clk);
    #2;
    e_valid = held; e_cnt = m_cnt; e_ovf = m_ovf; e_err = m_err;
    din_en = en; sel = s; din = d; word_ready = rdy; clr = c;
    lv = en && s == 6'b111111;
    if (held && rdy) held = 0;
    if (lv) begin
      if (held) m_ovf = 1;
      else begin
        nibs.push_back(d);
        if (nibs.size() == N) begin
          w = '0;
          foreach (nibs[i]) w[4*i +: 4] = nibs[i];
          expq.push_back(w);
          nibs.delete();
          held = 1;
        end
      end
    end else if (en) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
`ifdef NIBBLE_UNPACKER_FILLER_CHECK_EN
      if (d != 4'b0101) m_err = 1;
`endif
    end
    if (c) begin m_cnt = 0; m_ovf = 0; m_err = 0; end
  endtask

  task automatic live(input logic [3:0] d, input bit rdy);
    cycle(1, 6'b111111, d, rdy, 0);
  endtask

  task automatic reset_check(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    din_en = 0; word_ready = 0; clr = 0;
    model_reset();
    #1;
    chk({name, "_word"}, word, 0);
    chk({name, "_valid"}, word_valid, 0);
    chk({name, "_cnt"}, filler_cnt, 0);
    chk({name, "_ovf"}, ovf, 0);
    chk({name, "_err"}, filler_err, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("valid", word_valid, e_valid);
    chk("filler_cnt", filler_cnt, e_cnt);
    chk("ovf", ovf, e_ovf);
    chk("filler_err", filler_err, e_err);
    if (word_valid && word_ready) begin
      if (expq.size() == 0) chk("unexpected_word", word, 'x);
      else chk("word", word, expq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_word", word, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_cnt", filler_cnt, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) live(4'(i), 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
    live(4'hA, 0); live(4'hB, 0);
    repeat (3) cycle(1, 6'b000000, 4'b0101, 0, 0);
    live(4'hC, 0); live(4'hD, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) live(4'(i + 6), 0);
    live(4'h5, 0);
    cycle(0, 0, 0, 0, 0);
    live(4'h6, 1);
    live(4'h1, 0);
    cycle(1, 6'b011111, 4'b0101, 0, 0);
    cycle(1, 6'b111110, 4'b0101, 0, 0);
    live(4'h2, 0); live(4'h3, 0);
    cycle(0, 0, 0, 1, 0);
    repeat (260) cycle(1, 6'b000000, 4'b0101, 0, 0);
    cycle(1, 6'b000000, 4'b0101, 0, 1);
    cycle(1, 6'b101010, 4'b1111, 0, 0);
    live(4'h9, 0); live(4'h8, 0);
    reset_check("midword");
    for (int i = 0; i < 4; i++) live(4'(15 - i), 0);
    reset_check("midhold");
    for (int i = 0; i < 2000; i++) begin
      logic [5:0] s;
      logic [3:0] d;
      s = ($urandom_range(1) != 0) ? 6'b111111 : 6'($urandom);
      d = ($urandom_range(3) != 0 || s == 6'b111111) ? 4'($urandom) : 4'b0101;
      if (s != 6'b111111 && $urandom_range(3) != 0) d = 4'b0101;
      cycle($urandom_range(3) != 0, s, d, $urandom_range(2) != 0, $urandom_range(49) == 0);
    end
    for (int i = 0; i < 50 && expq.size() != 0; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    @(posedge clk);
    chk("drain_remaining", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
